sort_engine: RTL and testbench
==============================

Name: sort_engine

Overview:
- Parametrised in-place selection-sort engine with a private register-file RAM of DEPTH words of WIDTH bits.
- While idle, the host loads and reads words through an address/data port; a start pulse sorts the contents in place.
- Ascending or descending order is selectable per run; the block reports swap count and a completion pulse.
- Successor to the fixed 8x8 ascending sorter used in the lab designs.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of words; power of two, >=2.
- AW, $clog2(DEPTH), address width and swap_count width (derived, not overridden).

Ports:
- clk  input  1  clock, all state on rising edge
- nrst  input  1  reset, asynchronous, active-low
- start  input  1  begin sort; sampled only while ready=1
- descending  input  1  order select, captured on accepted start (0=ascending, 1=descending)
- wr  input  1  host write strobe; honoured only while ready=1
- addr  input  AW  host read/write address
- datain  input  WIDTH  host write data
- dataout  output  WIDTH  registered host read data
- ready  output  1  1 = idle and host port active; 0 = sorting
- done  output  1  one-cycle pulse in the cycle ready returns to 1 after a sort
- swap_count  output  AW  swaps performed by the last completed sort

Behaviour:
- Reset (nrst=0, immediate):
  - State returns to IDLE; ready=1, done=0, dataout=0, swap_count=0.
  - RAM contents are not cleared.
  - Reset mid-sort aborts the sort. RAM holds whatever partial swaps have completed; no write is half-applied.
- Host port, ready=1 only:
  - wr=1: mem[addr] <= datain at the clock edge.
  - wr=0: dataout <= mem[addr] at the clock edge (1-cycle read latency).
  - Write-then-read of the same address on consecutive cycles returns the new data.
- start while ready=1:
  - Enters sort and clears ready next cycle.
  - If wr=1 in the same cycle, start wins and the write is dropped.
  - descending is latched; swap_count resets to 0.
- While ready=0:
  - start, wr, addr, datain and descending are ignored.
  - dataout holds its last host-read value.
- Compare rule: unsigned.
  - Candidate replaces current extreme only on strictly less (ascending) or strictly greater (descending).
  - On ties, the lowest index wins and no swap occurs.
  - Stability is not guaranteed.
- FSM:
  - IDLE: ready=1; go to LOAD_I on accepted start, with i=0.
  - LOAD_I: read mem[i]; m=value, mi=i, j=i+1.
  - SCAN: read mem[j]; compare and update m/mi.
    - If j=DEPTH-1, go to DECIDE; else j++.
    - One word per cycle (pipelined read allowed).
  - DECIDE:
    - If mi==i, go to NEXT.
    - Else go to SWAP_A with the saved mem[i] value.
  - SWAP_A: mem[mi] <= old mem[i].
  - SWAP_B: mem[i] <= m; swap_count++; go to NEXT.
  - NEXT:
    - If i=DEPTH-2, go to IDLE: ready=1, done=1 for one cycle.
    - Else i++ and go to LOAD_I.
- Latency: start-to-done is at most DEPTH*DEPTH + 4*DEPTH cycles, and deterministic for given data.
- swap_count never exceeds DEPTH-1 (it fits in AW bits).
- Result: mem[0..DEPTH-1] is monotonic non-decreasing (ascending) or non-increasing (descending), and a permutation of the loaded data.

Test Plan:
- Default params: write {5,3,7,0,255,1,7,2} to addr 0..7, start, descending=0 -> done pulse once, ready=1; reads give {0,1,2,3,5,7,7,255}; swap_count matches the reference model.
- Same data, descending=1 -> reads {255,7,7,5,3,2,1,0}; done within 96 cycles of start.
- Already ascending {0..7}, start ascending -> swap_count=0, contents unchanged; all equal {9 x8} -> swap_count=0.
- start=1 with wr=1, addr=3, datain=0xAA while ready -> write dropped, sort runs; writes and starts during ready=0 are ignored, and the final data excludes them.
- Assert nrst=0 mid-sort (cycle 20) -> ready=1, done=0, swap_count=0 immediately; restart sort -> correct sorted result from the partially-sorted RAM.
- WIDTH=12, DEPTH=16 instance, random data incl. 0xFFF/0x000, 50 random runs both orders -> sorted permutation every run, latency <= 320 cycles.

Source files
------------

// File: rtl/sort_if.sv
// Host-side port bundle of the sort engine: load/read port, start/order control and status.
interface sort_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             start;
    logic             descending;
    logic             wr;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] datain;
    logic [WIDTH-1:0] dataout;
    logic             ready;
    logic             done;
    logic [AW-1:0]    swap_count;

    modport master (
        output start, descending, wr, addr, datain,
        input  dataout, ready, done, swap_count
    );

    modport slave (
        input  start, descending, wr, addr, datain,
        output dataout, ready, done, swap_count
    );
endinterface

// File: rtl/sort_engine.sv
// In-place selection sort over a private DEPTH x WIDTH register file.
// The host loads and reads words while idle; a start pulse sorts ascending or descending.
module sort_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   nrst,
    sort_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] A_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] A_ONE  = AW'(1);
    localparam logic [AW-1:0] LAST_J = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_I = AW'(DEPTH - 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_I = 3'd1,
        S_SCAN   = 3'd2,
        S_DECIDE = 3'd3,
        S_SWAP_A = 3'd4,
        S_SWAP_B = 3'd5,
        S_NEXT   = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_i;
    logic [AW-1:0]    r_j;
    logic [AW-1:0]    r_mi;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_old;
    logic             r_desc;
    logic             r_ready;
    logic             r_done;
    logic [WIDTH-1:0] r_dataout;
    logic [AW-1:0]    r_swap_count;
    logic             w_ready_nx;
    logic             w_done_nx;
    logic             w_start_acc;
    logic             w_host_wr;
    logic [WIDTH-1:0] w_cand;
    logic             w_better;

    // Host-side qualifiers and scan comparator
    always_comb begin
        w_start_acc = (r_state == S_IDLE) && bus.start;
        w_host_wr   = (r_state == S_IDLE) && !bus.start && bus.wr;
        w_cand      = r_mem[r_j];
        if (r_desc) begin
            w_better = (w_cand > r_m);
        end else begin
            w_better = (w_cand < r_m);
        end
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) w_state_nx = S_LOAD_I;
                else             w_state_nx = S_IDLE;
            end
            S_LOAD_I: w_state_nx = S_SCAN;
            S_SCAN: begin
                if (r_j == LAST_J) w_state_nx = S_DECIDE;
                else               w_state_nx = S_SCAN;
            end
            S_DECIDE: begin
                if (r_mi == r_i) w_state_nx = S_NEXT;
                else             w_state_nx = S_SWAP_A;
            end
            S_SWAP_A: w_state_nx = S_SWAP_B;
            S_SWAP_B: w_state_nx = S_NEXT;
            S_NEXT: begin
                if (r_i == LAST_I) w_state_nx = S_IDLE;
                else               w_state_nx = S_LOAD_I;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Status outputs decoded from the transition, registered below
    always_comb begin
        w_ready_nx = (w_state_nx == S_IDLE);
        w_done_nx  = (r_state == S_NEXT) && (w_state_nx == S_IDLE);
    end

    // Register file: host writes while idle, the two halves of a swap while sorting
    always_ff @(posedge clk) begin
        if (w_host_wr) begin
            r_mem[bus.addr] <= bus.datain;
        end else if (r_state == S_SWAP_A) begin
            r_mem[r_mi] <= r_old;
        end else if (r_state == S_SWAP_B) begin
            r_mem[r_i] <= r_m;
        end
    end

    // Sort datapath, host read register and status registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_i          <= A_ZERO;
            r_j          <= A_ZERO;
            r_mi         <= A_ZERO;
            r_m          <= {WIDTH{1'b0}};
            r_old        <= {WIDTH{1'b0}};
            r_desc       <= 1'b0;
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_dataout    <= {WIDTH{1'b0}};
            r_swap_count <= A_ZERO;
        end else begin
            r_ready <= w_ready_nx;
            r_done  <= w_done_nx;
            case (r_state)
                S_IDLE: begin
                    if (w_start_acc) begin
                        r_i          <= A_ZERO;
                        r_desc       <= bus.descending;
                        r_swap_count <= A_ZERO;
                    end
                    if (!bus.wr) begin
                        r_dataout <= r_mem[bus.addr];
                    end
                end
                S_LOAD_I: begin
                    r_m   <= r_mem[r_i];
                    r_old <= r_mem[r_i];
                    r_mi  <= r_i;
                    r_j   <= r_i + A_ONE;
                end
                S_SCAN: begin
                    // Strict compare: on ties the earlier index keeps the extreme
                    if (w_better) begin
                        r_m  <= w_cand;
                        r_mi <= r_j;
                    end
                    if (r_j != LAST_J) begin
                        r_j <= r_j + A_ONE;
                    end
                end
                S_SWAP_B: begin
                    r_swap_count <= r_swap_count + A_ONE;
                end
                S_NEXT: begin
                    if (r_i != LAST_I) begin
                        r_i <= r_i + A_ONE;
                    end
                end
                default: begin
                    r_i <= r_i;
                end
            endcase
        end
    end

    assign bus.dataout    = r_dataout;
    assign bus.ready      = r_ready;
    assign bus.done       = r_done;
    assign bus.swap_count = r_swap_count;
endmodule

// File: tb/tb_sort_engine.sv
// Bench for sort_engine: directed 8x8 cases plus randomized 12x16 runs against a queue-sort reference.
module tb_sort_engine;
    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    sort_if #(.WIDTH(8),  .DEPTH(8))  bus_a();
    sort_if #(.WIDTH(12), .DEPTH(16)) bus_b();

    sort_engine #(.WIDTH(8),  .DEPTH(8))  u_a (.clk(clk), .nrst(nrst), .bus(bus_a));
    sort_engine #(.WIDTH(12), .DEPTH(16)) u_b (.clk(clk), .nrst(nrst), .bus(bus_b));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drv(bit sel, bit st, bit ds, bit w, int a, int d);
        if (!sel) begin
            bus_a.start = st; bus_a.descending = ds; bus_a.wr = w;
            bus_a.addr = a[2:0]; bus_a.datain = d[7:0];
        end else begin
            bus_b.start = st; bus_b.descending = ds; bus_b.wr = w;
            bus_b.addr = a[3:0]; bus_b.datain = d[11:0];
        end
    endtask

    function automatic logic rdy(bit sel);
        return sel ? bus_b.ready : bus_a.ready;
    endfunction
    function automatic logic dn(bit sel);
        return sel ? bus_b.done : bus_a.done;
    endfunction
    function automatic logic [31:0] sc(bit sel);
        return sel ? 32'(bus_b.swap_count) : 32'(bus_a.swap_count);
    endfunction
    function automatic logic [31:0] dout(bit sel);
        return sel ? 32'(bus_b.dataout) : 32'(bus_a.dataout);
    endfunction

    task automatic load(bit sel, int d[$]);
        foreach (d[k]) begin
            @(negedge clk); drv(sel, 1'b0, 1'b0, 1'b1, k, d[k]);
        end
        @(negedge clk); drv(sel, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic hr(bit sel, int a, output logic [31:0] d);
        @(negedge clk); drv(sel, 1'b0, 1'b0, 1'b0, a, 0);
        @(negedge clk); d = dout(sel);
    endtask

    task automatic chk_mem(bit sel, int e[$], string tag);
        logic [31:0] v;
        foreach (e[k]) begin
            hr(sel, k, v);
            chk($sformatf("%s[%0d]", tag, k), v, e[k]);
        end
    endtask

    // Returns with one active edge already past the accepted start.
    task automatic start_sort(bit sel, bit desc, bit w, int a, int d);
        @(negedge clk); drv(sel, 1'b1, desc, w, a, d);
        @(negedge clk); drv(sel, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("ready_low_after_start", rdy(sel), 1'b0);
    endtask

    task automatic wait_done(bit sel, int cyc_in, int bound);
        int cyc = cyc_in;
        int dones = 0;
        while (rdy(sel) !== 1'b1 && cyc < 2 * bound) begin
            if (dn(sel) === 1'b1) dones++;
            @(negedge clk);
            cyc++;
        end
        chk("done_before_ready", dones, 0);
        chk("ready_back", rdy(sel), 1'b1);
        chk("done_pulse", dn(sel), 1'b1);
        chk("latency_ok", (cyc <= bound) ? 1 : 0, 1);
        @(negedge clk);
        chk("done_single", dn(sel), 1'b0);
    endtask

    // Reference: selection sort as described (strict compare, first extreme wins), counting swaps.
    function automatic int model_swaps(int d[$], bit desc);
        int a[$] = d;
        int n = 0;
        for (int i = 0; i < a.size() - 1; i++) begin
            int mi = i;
            for (int j = i + 1; j < a.size(); j++)
                if (desc ? (a[j] > a[mi]) : (a[j] < a[mi])) mi = j;
            if (mi != i) begin
                int t = a[i]; a[i] = a[mi]; a[mi] = t; n++;
            end
        end
        return n;
    endfunction

    function automatic void sorted(int d[$], bit desc, output int e[$]);
        e = d;
        if (desc) e.rsort(); else e.sort();
    endfunction

    task automatic full_run(bit sel, int d[$], bit desc, string tag);
        int e[$];
        int bound = sel ? 320 : 96;
        load(sel, d);
        start_sort(sel, desc, 1'b0, 0, 0);
        wait_done(sel, 1, bound);
        chk({tag, "_swaps"}, sc(sel), model_swaps(d, desc));
        sorted(d, desc, e);
        chk_mem(sel, e, tag);
    endtask

    initial begin
        int base[$] = '{5, 3, 7, 0, 255, 1, 7, 2};
        int asc[$]  = '{0, 1, 2, 3, 4, 5, 6, 7};
        int eq[$]   = '{9, 9, 9, 9, 9, 9, 9, 9};
        int e[$];
        logic [31:0] v;
        int rd[$];

        nrst = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        #12;
        chk("rst_ready", bus_a.ready, 1'b1);
        chk("rst_done", bus_a.done, 1'b0);
        chk("rst_dataout", dout(1'b0), 0);
        chk("rst_swaps", sc(1'b0), 0);
        @(negedge clk); nrst = 1'b1;

        full_run(1'b0, base, 1'b0, "asc");
        full_run(1'b0, base, 1'b1, "desc");
        full_run(1'b0, asc, 1'b0, "presorted");
        full_run(1'b0, eq, 1'b0, "equal");

        // start with a simultaneous write, then noise while busy
        load(1'b0, base);
        hr(1'b0, 4, v);
        chk("pre_read", v, 255);
        start_sort(1'b0, 1'b0, 1'b1, 3, 'hAA);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); drv(1'b0, 1'b1, 1'b1, k[0], k, 'h55);
            chk("busy_ready", rdy(1'b0), 1'b0);
            chk("busy_hold", dout(1'b0), 255);
        end
        @(negedge clk); drv(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        wait_done(1'b0, 7, 96);
        chk("ign_swaps", sc(1'b0), model_swaps(base, 1'b0));
        sorted(base, 1'b0, e);
        chk_mem(1'b0, e, "ignored");

        // reset mid-sort, then restart from the partial RAM
        load(1'b0, base);
        start_sort(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (19) @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("mid_rst_ready", rdy(1'b0), 1'b1);
        chk("mid_rst_done", dn(1'b0), 1'b0);
        chk("mid_rst_swaps", sc(1'b0), 0);
        @(negedge clk); nrst = 1'b1;
        start_sort(1'b0, 1'b0, 1'b0, 0, 0);
        wait_done(1'b0, 1, 96);
        chk_mem(1'b0, e, "after_rst");

        // randomized 12x16 runs, both orders, with extremes planted
        for (int r = 0; r < 50; r++) begin
            int p;
            int q;
            rd.delete();
            for (int k = 0; k < 16; k++)
                rd.push_back((r % 3 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 4095)));
            p = int'($urandom_range(0, 15));
            q = (p + 1 + int'($urandom_range(0, 14))) % 16;
            rd[p] = 'hFFF;
            rd[q] = 0;
            full_run(1'b1, rd, r[0], $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
